// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - lock/request inputs and reset/status outputs of reset_sequencer
interface reset_sequencer_if;
  logic       pll_lock;
  logic       fw_reset_req;
  logic       wdt_reset_req;
  logic       periph_rst_n;
  logic       core_rst_n;
  logic [1:0] reset_cause;
  logic       lock_timeout;
  logic [7:0] reset_count;

  modport master (
    output pll_lock, fw_reset_req, wdt_reset_req,
    input  periph_rst_n, core_rst_n, reset_cause, lock_timeout, reset_count
  );

  modport slave (
    input  pll_lock, fw_reset_req, wdt_reset_req,
    output periph_rst_n, core_rst_n, reset_cause, lock_timeout, reset_count
  );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release after PLL lock with request/lock-loss restart
module reset_sequencer #(
  parameter int ASSERT_CYCLES = 16,
  parameter int STAGE_CYCLES  = 8,
  parameter int LOCK_TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  reset_sequencer_if.slave rs
);

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, REL_PERIPH, RUN} state_e;

  localparam logic [7:0] HOLD_LAST  = 8'(ASSERT_CYCLES - 1);
  localparam logic [7:0] STAGE_LAST = 8'(STAGE_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(LOCK_TIMEOUT - 1);

  generate
    if (ASSERT_CYCLES < 1 || ASSERT_CYCLES > 255 ||
        STAGE_CYCLES  < 1 || STAGE_CYCLES  > 255 ||
        LOCK_TIMEOUT  < 1 || LOCK_TIMEOUT  > 255) begin : g_bad_param
      $error("reset_sequencer: cycle parameters must lie in 1..255");
    end
  endgenerate

  state_e     state_q, state_d;
  logic [7:0] ctr_q, ctr_d;
  logic       sync1_q, sync1_d;
  logic       lock_s_q, lock_s_d;
  logic       lock_dly_q, lock_dly_d;
  logic       periph_q, periph_d;
  logic       core_q, core_d;
  logic [1:0] cause_q, cause_d;
  logic       timeout_q, timeout_d;
  logic [7:0] count_q, count_d;

  logic lock_lost;
  logic restart;

  assign lock_lost = lock_dly_q & ~lock_s_q;

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= WAIT_LOCK;
      ctr_q      <= '0;
      sync1_q    <= 1'b0;
      lock_s_q   <= 1'b0;
      lock_dly_q <= 1'b0;
      periph_q   <= 1'b0;
      core_q     <= 1'b0;
      cause_q    <= 2'b00;
      timeout_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      sync1_q    <= sync1_d;
      lock_s_q   <= lock_s_d;
      lock_dly_q <= lock_dly_d;
      periph_q   <= periph_d;
      core_q     <= core_d;
      cause_q    <= cause_d;
      timeout_q  <= timeout_d;
      count_q    <= count_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q || ctr_q == WAIT_LAST) state_d = HOLD;
      end
      HOLD: begin
        if (ctr_q == HOLD_LAST) state_d = REL_PERIPH;
      end
      REL_PERIPH: begin
        if (lock_lost)                state_d = WAIT_LOCK;
        else if (ctr_q == STAGE_LAST) state_d = RUN;
      end
      RUN: begin
        if (lock_lost)                                  state_d = WAIT_LOCK;
        else if (rs.wdt_reset_req || rs.fw_reset_req)   state_d = HOLD;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // output and bookkeeping logic, registered from the next state
  always_comb begin
    sync1_d    = rs.pll_lock;
    lock_s_d   = sync1_q;
    lock_dly_d = lock_s_q;
    ctr_d      = (state_d != state_q) ? 8'd0 : ctr_q + 8'd1;

    periph_d   = (state_d == REL_PERIPH) || (state_d == RUN);
    core_d     = (state_d == RUN);

    // Any fall back from REL_PERIPH/RUN is a sequencer-initiated reset.
    restart    = ((state_q == REL_PERIPH) || (state_q == RUN)) &&
                 ((state_d == WAIT_LOCK)  || (state_d == HOLD));

    cause_d    = cause_q;
    count_d    = count_q;
    if (restart) begin
      if (state_d == WAIT_LOCK)   cause_d = 2'b11;
      else if (rs.wdt_reset_req)  cause_d = 2'b10;
      else                        cause_d = 2'b01;
      if (count_q != 8'hff) count_d = count_q + 8'd1;
    end

    timeout_d  = timeout_q |
                 ((state_q == WAIT_LOCK) && (state_d == HOLD) && !lock_s_q);
  end

  assign rs.periph_rst_n = periph_q;
  assign rs.core_rst_n   = core_q;
  assign rs.reset_cause  = cause_q;
  assign rs.lock_timeout = timeout_q;
  assign rs.reset_count  = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - randomized self-checking bench for reset_sequencer
module tb_reset_sequencer;
  localparam int ASSERT_CYCLES = 16;
  localparam int STAGE_CYCLES  = 8;
  localparam int LOCK_TIMEOUT  = 255;

  localparam int P_WAIT = 0, P_HOLD = 1, P_REL = 2, P_RUN = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  reset_sequencer_if rif ();

  reset_sequencer #(
    .ASSERT_CYCLES(ASSERT_CYCLES),
    .STAGE_CYCLES (STAGE_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .rs     (rif.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference: phase plus the edge it was entered on; lock history of pll_lock samples
  int         edge_no = 0;
  int         m_phase = P_WAIT;
  int         m_start = 0;
  logic [1:0] m_cause = 2'b00;
  bit         m_to = 1'b0;
  int         m_cnt = 0;
  bit         h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    int  elapsed;
    int  nxt;
    bit  lost;
    bit  lock_seen;
    m_valid = 1'b1;
    if (!reset_n) begin
      edge_no = 0;
      m_phase = P_WAIT;
      m_start = 0;
      m_cause = 2'b00;
      m_to    = 1'b0;
      m_cnt   = 0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    end else begin
      edge_no   = edge_no + 1;
      elapsed   = edge_no - m_start;
      lock_seen = h2;
      lost      = h3 && !h2;
      nxt       = m_phase;
      case (m_phase)
        P_WAIT: begin
          if (lock_seen) nxt = P_HOLD;
          else if (elapsed == LOCK_TIMEOUT) begin
            nxt  = P_HOLD;
            m_to = 1'b1;
          end
        end
        P_HOLD: if (elapsed == ASSERT_CYCLES) nxt = P_REL;
        P_REL: begin
          if (lost) begin
            nxt = P_WAIT; m_cause = 2'b11; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          end else if (elapsed == STAGE_CYCLES) nxt = P_RUN;
        end
        default: begin
          if (lost) begin
            nxt = P_WAIT; m_cause = 2'b11; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          end else if (rif.wdt_reset_req || rif.fw_reset_req) begin
            nxt = P_HOLD;
            m_cause = rif.wdt_reset_req ? 2'b10 : 2'b01;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          end
        end
      endcase
      if (nxt != m_phase) m_start = edge_no;
      m_phase = nxt;
      h3 = h2; h2 = h1; h1 = rif.pll_lock;
    end
  end

  always @(negedge clk) begin
    logic [12:0] exp_v;
    logic [12:0] act_v;
    if (m_valid) begin
      exp_v = {m_phase >= P_REL, m_phase == P_RUN, m_cause, m_to, 8'(m_cnt)};
      act_v = {rif.periph_rst_n, rif.core_rst_n, rif.reset_cause, rif.lock_timeout, rif.reset_count};
      n_vec = n_vec + 1;
      if (act_v !== exp_v) begin
        n_err = n_err + 1;
        $display("FAIL model edge=%0d got {p,c,cause,to,cnt}=%b required %b", edge_no, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec = n_vec + 1;
    if (act !== exp_v) begin
      n_err = n_err + 1;
      $display("FAIL %s edge=%0d got %0h required %0h", name, edge_no, act, exp_v);
    end
  endtask

  task automatic wait_edge(input int n);
    for (int i = 0; i < 2000 && edge_no < n; i++) @(negedge clk);
    chk("wait_edge", edge_no, n);
  endtask

  task automatic pulse(input bit fw, input bit wdt);
    rif.fw_reset_req  = fw;
    rif.wdt_reset_req = wdt;
    @(negedge clk);
    rif.fw_reset_req  = 1'b0;
    rif.wdt_reset_req = 1'b0;
  endtask

  initial begin
    rif.pll_lock      = 1'b1;
    rif.fw_reset_req  = 1'b0;
    rif.wdt_reset_req = 1'b0;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;

    // power-on sequence
    wait_edge(18);
    chk("por_periph_18", rif.periph_rst_n, 0);
    wait_edge(19);
    chk("por_periph_19", rif.periph_rst_n, 1);
    wait_edge(26);
    chk("por_core_26", rif.core_rst_n, 0);
    wait_edge(27);
    chk("por_core_27", rif.core_rst_n, 1);
    chk("por_cause", rif.reset_cause, 0);
    chk("por_count", rif.reset_count, 0);

    // firmware request
    wait_edge(30);
    pulse(1'b1, 1'b0);
    chk("fw_periph_31", rif.periph_rst_n, 0);
    chk("fw_cause", rif.reset_cause, 1);
    chk("fw_count", rif.reset_count, 1);
    wait_edge(46);
    chk("fw_periph_46", rif.periph_rst_n, 0);
    wait_edge(47);
    chk("fw_periph_47", rif.periph_rst_n, 1);
    wait_edge(55);
    chk("fw_core_55", rif.core_rst_n, 1);

    // simultaneous wdt and fw
    wait_edge(60);
    pulse(1'b1, 1'b1);
    chk("sim_cause", rif.reset_cause, 2);
    chk("sim_count", rif.reset_count, 2);
    wait_edge(85);
    chk("sim_core_85", rif.core_rst_n, 1);

    // lock loss and relock
    wait_edge(90);
    rif.pll_lock = 1'b0;
    wait_edge(92);
    chk("loss_core_92", rif.core_rst_n, 1);
    wait_edge(93);
    chk("loss_resets_93", {rif.periph_rst_n, rif.core_rst_n}, 0);
    chk("loss_cause", rif.reset_cause, 3);
    chk("loss_count", rif.reset_count, 3);
    wait_edge(100);
    rif.pll_lock = 1'b1;
    wait_edge(119);
    chk("relock_periph_119", rif.periph_rst_n, 1);
    wait_edge(126);
    chk("relock_core_126", rif.core_rst_n, 0);
    wait_edge(127);
    chk("relock_core_127", rif.core_rst_n, 1);

    // random requests and lock glitches, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      rif.fw_reset_req  = ($urandom_range(0, 19) == 0);
      rif.wdt_reset_req = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 149) == 0) rif.pll_lock = ~rif.pll_lock;
      @(negedge clk);
    end
    rif.fw_reset_req  = 1'b0;
    rif.wdt_reset_req = 1'b0;

    // lock timeout from reset
    rif.pll_lock = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {rif.periph_rst_n, rif.core_rst_n, rif.reset_cause, rif.lock_timeout, rif.reset_count}, 0);
    reset_n = 1'b1;
    wait_edge(254);
    chk("to_flag_254", rif.lock_timeout, 0);
    wait_edge(255);
    chk("to_flag_255", rif.lock_timeout, 1);
    wait_edge(270);
    chk("to_periph_270", rif.periph_rst_n, 0);
    wait_edge(271);
    chk("to_periph_271", rif.periph_rst_n, 1);

    // abort during REL_PERIPH
    wait_edge(274);
    reset_n = 1'b0;
    rif.pll_lock = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {rif.periph_rst_n, rif.core_rst_n, rif.reset_cause, rif.lock_timeout, rif.reset_count}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // saturation of the reset counter
    wait_edge(28);
    chk("sat_core_run", rif.core_rst_n, 1);
    for (int i = 0; i < 300; i++) begin
      pulse(1'b1, 1'b0);
      repeat (24) @(negedge clk);
    end
    chk("sat_count", rif.reset_count, 255);
    chk("sat_cause", rif.reset_cause, 1);
    chk("sat_core", rif.core_rst_n, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
